// File: rtl/fractal_sync_mp_rx.sv
// fractal_sync_mp_rx: multi-port sync request receiver with per-port FWFT FIFOs and a round-robin/merging output arbiter.
module fractal_sync_mp_rx #(
  parameter int N_PORTS    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int AGGR_W     = 4,
  parameter int ID_W       = 4,
  parameter int SRC_W      = 2,
  parameter int COMB_IN    = 0,
  parameter int MERGE      = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_PORTS-1:0]          req_sync_i,
  input  logic [N_PORTS*AGGR_W-1:0]   req_aggr_i,
  input  logic [N_PORTS*ID_W-1:0]     req_id_i,
  input  logic [N_PORTS*SRC_W-1:0]    req_src_i,
  output logic [N_PORTS-1:0]          local_o,
  output logic [N_PORTS-1:0]          root_o,
  output logic [N_PORTS-1:0]          error_overflow_o,
  input  logic                        clear_error_i,
  output logic [N_PORTS-1:0]          empty_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [AGGR_W-2:0]           out_aggr_o,
  output logic [ID_W-1:0]             out_id_o,
  output logic [SRC_W+N_PORTS-1:0]    out_src_o
);
  localparam int RW = $clog2(N_PORTS);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = SRC_W + N_PORTS;
  typedef struct packed {
    logic [AGGR_W-2:0] aggr;
    logic [ID_W-1:0]   id;
    logic [SW-1:0]     src;
  } entry_t;
  typedef enum logic {FREE, LOCKED} state_t;
  logic [N_PORTS-1:0]             s_valid;
  logic [N_PORTS-1:0][AGGR_W-1:0] s_aggr;
  logic [N_PORTS-1:0][ID_W-1:0]   s_id;
  logic [N_PORTS-1:0][SRC_W-1:0]  s_src;
  generate
    if (COMB_IN != 0) begin : g_comb
      assign s_valid = req_sync_i & {N_PORTS{~rst_i}};
      assign s_aggr  = req_aggr_i;
      assign s_id    = req_id_i;
      assign s_src   = req_src_i;
    end else begin : g_reg
      logic [N_PORTS-1:0]             valid_q, valid_d;
      logic [N_PORTS-1:0][AGGR_W-1:0] aggr_q, aggr_d, aggr_in;
      logic [N_PORTS-1:0][ID_W-1:0]   id_q, id_d, id_in;
      logic [N_PORTS-1:0][SRC_W-1:0]  src_q, src_d, src_in;
      assign aggr_in = req_aggr_i;
      assign id_in   = req_id_i;
      assign src_in  = req_src_i;
      always_comb begin
        valid_d = req_sync_i;
        aggr_d  = aggr_q;
        id_d    = id_q;
        src_d   = src_q;
        for (int p = 0; p < N_PORTS; p++) begin
          aggr_d[p] = req_sync_i[p] ? aggr_in[p] : aggr_q[p];
          id_d[p]   = req_sync_i[p] ? id_in[p]   : id_q[p];
          src_d[p]  = req_sync_i[p] ? src_in[p]  : src_q[p];
        end
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_q <= '0;
          aggr_q  <= '0;
          id_q    <= '0;
          src_q   <= '0;
        end else begin
          valid_q <= valid_d;
          aggr_q  <= aggr_d;
          id_q    <= id_d;
          src_q   <= src_d;
        end
      end
      assign s_valid = valid_q;
      assign s_aggr  = aggr_q;
      assign s_id    = id_q;
      assign s_src   = src_q;
    end
  endgenerate
  entry_t [N_PORTS-1:0][FIFO_DEPTH-1:0] mem_q, mem_d;
  logic   [N_PORTS-1:0][PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic   [N_PORTS-1:0][CW-1:0]         cnt_q, cnt_d;
  logic   [N_PORTS-1:0]                 err_q, err_d, push, pop, full, empty, acc;
  entry_t [N_PORTS-1:0]                 head, new_e;
  state_t             state_q, state_d;
  logic [RW-1:0]      rr_q, rr_d, grant_q, grant_d, grant_c, grant;
  logic               merge_q, merge_d, merge_c, merge, hs, found;
  logic [RW:0]        idx;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
    return (v == PW'(FIFO_DEPTH - 1)) ? '0 : v + 1'b1;
  endfunction
  always_comb begin
    head  = '0;
    new_e = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      empty[p]      = cnt_q[p] == '0;
      full[p]       = cnt_q[p] == CW'(FIFO_DEPTH);
      head[p]       = mem_q[p][rp_q[p]];
      local_o[p]    = s_valid[p] & s_aggr[p][0];
      root_o[p]     = s_valid[p] & (s_aggr[p] == AGGR_W'(1));
      push[p]       = s_valid[p] & ~s_aggr[p][0];
      new_e[p].aggr = s_aggr[p][AGGR_W-1:1];
      new_e[p].id   = s_id[p];
      new_e[p].src  = {s_src[p], N_PORTS'(1) << p};
    end
  end
  assign empty_o          = empty;
  assign out_valid_o      = ~&empty;
  assign error_overflow_o = err_q;
  // Circular scan from rr picks the first non-empty port.
  always_comb begin
    grant_c = rr_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = {1'b0, rr_q} + (RW+1)'(i);
      idx = idx >= (RW+1)'(N_PORTS) ? idx - (RW+1)'(N_PORTS) : idx;
      if (!found && !empty[idx[RW-1:0]]) begin
        grant_c = idx[RW-1:0];
        found   = 1'b1;
      end
    end
    merge_c = (MERGE != 0) && !(|empty);
    for (int p = 1; p < N_PORTS; p++)
      if (head[p].aggr != head[0].aggr || head[p].id != head[0].id) merge_c = 1'b0;
    grant      = state_q == LOCKED ? grant_q : grant_c;
    merge      = state_q == LOCKED ? merge_q : merge_c;
    hs         = out_valid_o & out_ready_i;
    pop        = hs ? (merge ? '1 : N_PORTS'(1) << grant) : '0;
    out_aggr_o = head[grant].aggr;
    out_id_o   = head[grant].id;
    out_src_o  = merge ? {head[0].src[SW-1:N_PORTS], {N_PORTS{1'b1}}} : head[grant].src;
    state_d    = state_q == FREE ? (out_valid_o & ~out_ready_i ? LOCKED : FREE) : (hs ? FREE : LOCKED);
    grant_d    = state_q == FREE ? grant_c : grant_q;
    merge_d    = state_q == FREE ? merge_c : merge_q;
    rr_d       = hs && !merge ? (grant == RW'(N_PORTS - 1) ? '0 : grant + 1'b1) : rr_q;
  end
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    acc   = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      acc[p] = push[p] & (~full[p] | pop[p]);
      if (acc[p]) begin
        mem_d[p][wp_q[p]] = new_e[p];
        wp_d[p]           = inc(wp_q[p]);
      end
      rp_d[p]  = pop[p] ? inc(rp_q[p]) : rp_q[p];
      cnt_d[p] = cnt_q[p] + CW'(acc[p]) - CW'(pop[p]);
      err_d[p] = (push[p] & full[p] & ~pop[p]) ? 1'b1 : clear_error_i ? 1'b0 : err_q[p];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FREE;
      rr_q    <= '0;
      grant_q <= '0;
      merge_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      merge_q <= merge_d;
    end
  end
endmodule

// File: tb/tb_fractal_sync_mp_rx.sv
// tb_fractal_sync_mp_rx: directed + random stimulus checked cycle by cycle against a queue-based reference model.
module tb_fractal_sync_mp_rx;
  localparam int N = 2, D = 2, AW = 4, IW = 4, SW = 2;
  localparam int EW = AW - 1 + IW + SW + N;
  logic              clk_i = 1'b0, rst_i = 1'b1;
  logic [N-1:0]      req_sync_i = '0;
  logic [N*AW-1:0]   req_aggr_i = '0;
  logic [N*IW-1:0]   req_id_i = '0;
  logic [N*SW-1:0]   req_src_i = '0;
  logic              clear_error_i = 1'b0, out_ready_i = 1'b0;
  logic [N-1:0]      local_o, root_o, error_overflow_o, empty_o;
  logic              out_valid_o;
  logic [AW-2:0]     out_aggr_o;
  logic [IW-1:0]     out_id_o;
  logic [SW+N-1:0]   out_src_o;
  int n_cmp = 0, n_bad = 0;
  fractal_sync_mp_rx #(.N_PORTS(N), .FIFO_DEPTH(D), .AGGR_W(AW), .ID_W(IW), .SRC_W(SW),
                       .COMB_IN(0), .MERGE(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_sync_i(req_sync_i), .req_aggr_i(req_aggr_i),
    .req_id_i(req_id_i), .req_src_i(req_src_i), .local_o(local_o), .root_o(root_o),
    .error_overflow_o(error_overflow_o), .clear_error_i(clear_error_i), .empty_o(empty_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_aggr_o(out_aggr_o),
    .out_id_o(out_id_o), .out_src_o(out_src_o));
  always #5 clk_i = ~clk_i;
  logic [N-1:0]    m_sv;
  logic [AW-1:0]   m_sa [N];
  logic [IW-1:0]   m_si [N];
  logic [SW-1:0]   m_ss [N];
  logic [EW-1:0]   q [N][$];
  logic [N-1:0]    m_err;
  int              m_rr, m_hg;
  bit              m_lock, m_hm;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_sv = '0; m_err = '0; m_rr = 0; m_hg = 0; m_lock = 0; m_hm = 0;
    for (int p = 0; p < N; p++) begin
      q[p].delete(); m_sa[p] = '0; m_si[p] = '0; m_ss[p] = '0;
    end
  endtask
  task automatic step(input logic [N-1:0] sync, input logic [N*AW-1:0] aggr, input logic [N*IW-1:0] id,
                      input logic [N*SW-1:0] src, input logic rdy, input logic clr);
    logic [N-1:0] ne, loc, rt, emp, set;
    logic [EW-1:0] hg, h0, e;
    logic [N-1:0] oh;
    bit ov, m, f, hs;
    int g;
    req_sync_i = sync; req_aggr_i = aggr; req_id_i = id; req_src_i = src;
    out_ready_i = rdy; clear_error_i = clr;
    #1;
    for (int p = 0; p < N; p++) begin
      ne[p]  = q[p].size() != 0;
      emp[p] = !ne[p];
      loc[p] = m_sv[p] && m_sa[p][0];
      rt[p]  = m_sv[p] && m_sa[p] == 4'd1;
    end
    ov = |ne;
    g = m_rr; f = 0;
    for (int i = 0; i < N; i++)
      if (!f && ne[(m_rr + i) % N]) begin g = (m_rr + i) % N; f = 1; end
    if (m_lock) g = m_hg;
    m = &ne;
    if (m) for (int p = 1; p < N; p++) if (q[p][0][EW-1:SW+N] != q[0][0][EW-1:SW+N]) m = 0;
    if (m_lock) m = m_hm;
    chk("local", 32'(local_o), 32'(loc));
    chk("root", 32'(root_o), 32'(rt));
    chk("empty", 32'(empty_o), 32'(emp));
    chk("out_valid", 32'(out_valid_o), 32'(ov));
    chk("overflow", 32'(error_overflow_o), 32'(m_err));
    if (ov) begin
      hg = q[g][0]; h0 = q[0][0];
      chk("out_aggr", 32'(out_aggr_o), 32'(hg[EW-1 -: AW-1]));
      chk("out_id", 32'(out_id_o), 32'(hg[SW+N +: IW]));
      chk("out_src", 32'(out_src_o), m ? 32'({h0[N +: SW], {N{1'b1}}}) : 32'(hg[SW+N-1:0]));
    end
    hs = ov && rdy;
    if (hs) begin
      if (m) for (int p = 0; p < N; p++) void'(q[p].pop_front());
      else begin void'(q[g].pop_front()); m_rr = (g + 1) % N; end
      m_lock = 0;
    end else if (ov && !m_lock) begin
      m_lock = 1; m_hg = g; m_hm = m;
    end
    set = '0;
    for (int p = 0; p < N; p++)
      if (m_sv[p] && !m_sa[p][0]) begin
        oh = N'(1) << p;
        e = {m_sa[p][AW-1:1], m_si[p], m_ss[p], oh};
        if (q[p].size() < D) q[p].push_back(e); else set[p] = 1'b1;
      end
    m_err = set | (clr ? '0 : m_err);
    m_sv = sync;
    for (int p = 0; p < N; p++)
      if (sync[p]) begin
        m_sa[p] = aggr[p*AW +: AW]; m_si[p] = id[p*IW +: IW]; m_ss[p] = src[p*SW +: SW];
      end
    @(negedge clk_i);
  endtask
  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, rdy, 1'b0);
  endtask
  task automatic do_reset();
    req_sync_i = '0; clear_error_i = 1'b0; out_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("rst_empty", 32'(empty_o), 32'h3);
    chk("rst_local", 32'(local_o), 32'h0);
    chk("rst_root", 32'(root_o), 32'h0);
    chk("rst_overflow", 32'(error_overflow_o), 32'h0);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask
  initial begin
    logic [N-1:0] sy;
    logic [N*AW-1:0] ag;
    logic [N*IW-1:0] idv;
    logic [N*SW-1:0] sr;
    @(negedge clk_i);
    do_reset();
    step(2'b01, {4'b0000, 4'b0001}, '0, '0, 1'b1, 1'b0);
    idle(1'b1, 3);
    step(2'b10, {4'b0110, 4'b0000}, {4'd3, 4'd0}, {2'd2, 2'd0}, 1'b1, 1'b0);
    idle(1'b1, 3);
    for (int i = 0; i < 3; i++) step(2'b01, {4'b0000, 4'b0010}, {4'd0, 4'(i)}, '0, 1'b0, 1'b0);
    idle(1'b0, 3);
    chk("ovf_sticky", 32'(error_overflow_o), 32'h1);
    step('0, '0, '0, '0, 1'b0, 1'b1);
    idle(1'b1, 4);
    chk("ovf_cleared", 32'(error_overflow_o), 32'h0);
    step(2'b11, {4'b0100, 4'b0100}, {4'd5, 4'd5}, {2'd1, 2'd2}, 1'b1, 1'b0);
    idle(1'b1, 3);
    step(2'b11, {4'b0010, 4'b0010}, {4'd2, 4'd1}, {2'd3, 2'd1}, 1'b0, 1'b0);
    idle(1'b0, 4);
    idle(1'b1, 4);
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      for (int p = 0; p < N; p++) begin
        int a;
        a = $urandom_range(0, 7);
        sy[p] = $urandom_range(0, 2) != 0;
        ag[p*AW +: AW] = a == 0 ? 4'b0001 : a == 1 ? 4'b0011 : a < 5 ? 4'b0100 : 4'(($urandom_range(1, 7)) << 1);
        idv[p*IW +: IW] = 4'($urandom_range(0, 1));
        sr[p*SW +: SW] = 2'($urandom);
      end
      step(sy, ag, idv, sr, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    do_reset();
    idle(1'b1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
